rx_frame_buffer: RTL and testbench

Receive-side frame buffer sitting directly downstream of the UART receiver. Captures each completed 32-bit receive word plus its parity/stop error flags into a circular FIFO. Exposes a registered read handshake to the host side. Keeps sticky overflow and saturating per-error statistics counters.

---
 rtl/rx_frame_buffer_if.sv | 37 +++
 rtl/rx_frame_buffer.sv | 98 +++++++++
 tb/tb_rx_frame_buffer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rx_frame_buffer_if.sv
// Host/receiver-facing signal bundle for rx_frame_buffer.
// master = receiver + host side, slave = the frame buffer.
interface rx_frame_buffer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
);
  logic              Rx_Valid;
  logic [DATA_W-1:0] Rx_dataOut;
  logic              Parity_Error;
  logic              Stop_Error;
  logic              Rd_En;
  logic              Clr_Stat;
  logic [DATA_W-1:0] Rd_Data;
  logic              Rd_PErr;
  logic              Rd_SErr;
  logic              Rd_Valid;
  logic              Empty;
  logic              Full;
  logic [ADDR_W:0]   Level;
  logic              Overflow;
  logic [CNT_W-1:0]  Parity_Cnt;
  logic [CNT_W-1:0]  Stop_Cnt;
  logic [CNT_W-1:0]  Drop_Cnt;

  modport master (
    output Rx_Valid, Rx_dataOut, Parity_Error, Stop_Error, Rd_En, Clr_Stat,
    input  Rd_Data, Rd_PErr, Rd_SErr, Rd_Valid, Empty, Full, Level,
           Overflow, Parity_Cnt, Stop_Cnt, Drop_Cnt
  );

  modport slave (
    input  Rx_Valid, Rx_dataOut, Parity_Error, Stop_Error, Rd_En, Clr_Stat,
    output Rd_Data, Rd_PErr, Rd_SErr, Rd_Valid, Empty, Full, Level,
           Overflow, Parity_Cnt, Stop_Cnt, Drop_Cnt
  );
endinterface

// File: rtl/rx_frame_buffer.sv
// UART receive frame FIFO with registered pop, sticky overflow and saturating error stats.
// Optional: define RX_DROP_ERRORED_EN to discard frames carrying parity/stop errors.
module rx_frame_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic               Clock_In,
  input  logic               Reset,
  rx_frame_buffer_if.slave   bus
);
  localparam int ENT_W = DATA_W + 2;
  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);

  logic [DEPTH-1:0][ENT_W-1:0] mem;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   level;
  logic [DATA_W-1:0] rd_data_q;
  logic [1:0]        rd_flags_q;
  logic              rd_valid_q;
  logic              ovf_q;
  logic [CNT_W-1:0]  pcnt_q, scnt_q, dcnt_q;

  logic empty, full, wr_req, rd_acc, wr_acc, drop;

  assign empty  = (level == '0);
  assign full   = (level == LVL_FULL);
  assign rd_acc = bus.Rd_En & ~empty;

`ifdef RX_DROP_ERRORED_EN
  assign wr_req      = bus.Rx_Valid & ~bus.Parity_Error & ~bus.Stop_Error;
  assign bus.Rd_PErr = 1'b0;
  assign bus.Rd_SErr = 1'b0;
`else
  assign wr_req      = bus.Rx_Valid;
  assign bus.Rd_PErr = rd_flags_q[0];
  assign bus.Rd_SErr = rd_flags_q[1];
`endif

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_acc = wr_req & (~full | rd_acc);
  assign drop   = wr_req & full & ~rd_acc;

  // Clear wins over the old value but not over a coincident event.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] cnt,
                                            input logic ev, input logic clr);
    if (clr)                  return CNT_W'(ev);
    else if (ev && cnt != '1) return cnt + CNT_W'(1);
    else                      return cnt;
  endfunction

  always_ff @(posedge Clock_In) begin
    if (wr_acc) mem[wr_ptr] <= {bus.Stop_Error, bus.Parity_Error, bus.Rx_dataOut};
  end

  always_ff @(posedge Clock_In or negedge Reset) begin
    if (!Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      rd_data_q  <= '0;
      rd_flags_q <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      pcnt_q     <= '0;
      scnt_q     <= '0;
      dcnt_q     <= '0;
    end else begin
      rd_valid_q <= rd_acc;
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_acc) begin
        rd_ptr     <= rd_ptr + ADDR_W'(1);
        rd_data_q  <= mem[rd_ptr][DATA_W-1:0];
        rd_flags_q <= mem[rd_ptr][ENT_W-1:DATA_W];
      end
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      ovf_q  <= (ovf_q & ~bus.Clr_Stat) | drop;
      pcnt_q <= bump(pcnt_q, bus.Rx_Valid & bus.Parity_Error, bus.Clr_Stat);
      scnt_q <= bump(scnt_q, bus.Rx_Valid & bus.Stop_Error, bus.Clr_Stat);
      dcnt_q <= bump(dcnt_q, drop, bus.Clr_Stat);
    end
  end

  assign bus.Rd_Data    = rd_data_q;
  assign bus.Rd_Valid   = rd_valid_q;
  assign bus.Empty      = empty;
  assign bus.Full       = full;
  assign bus.Level      = level;
  assign bus.Overflow   = ovf_q;
  assign bus.Parity_Cnt = pcnt_q;
  assign bus.Stop_Cnt   = scnt_q;
  assign bus.Drop_Cnt   = dcnt_q;
endmodule

// File: tb/tb_rx_frame_buffer.sv
// Randomized + directed bench for rx_frame_buffer against a queue-based reference model.
module tb_rx_frame_buffer;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic Clock_In = 1'b0;
  logic Reset;
  int   n_chk = 0;
  int   n_err = 0;

  rx_frame_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  rx_frame_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .Clock_In (Clock_In),
    .Reset    (Reset),
    .bus      (bus)
  );

  always #5 Clock_In = ~Clock_In;

  // Reference model: FIFO as a queue, stats as plain integers.
  logic [DATA_W+1:0] q[$];
  logic [DATA_W-1:0] m_data;
  logic              m_perr, m_serr, m_vld, m_ovf;
  int                m_pcnt, m_scnt, m_dcnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_reset();
    q.delete();
    m_data = '0; m_perr = 0; m_serr = 0; m_vld = 0; m_ovf = 0;
    m_pcnt = 0; m_scnt = 0; m_dcnt = 0;
  endtask

  task automatic check_all();
    chk("level",    64'(bus.Level),      64'(q.size()));
    chk("empty",    64'(bus.Empty),      64'(q.size() == 0));
    chk("full",     64'(bus.Full),       64'(q.size() == DEPTH));
    chk("rd_valid", 64'(bus.Rd_Valid),   64'(m_vld));
    chk("rd_data",  64'(bus.Rd_Data),    64'(m_data));
    chk("rd_perr",  64'(bus.Rd_PErr),    64'(m_perr));
    chk("rd_serr",  64'(bus.Rd_SErr),    64'(m_serr));
    chk("overflow", 64'(bus.Overflow),   64'(m_ovf));
    chk("par_cnt",  64'(bus.Parity_Cnt), 64'(m_pcnt));
    chk("stop_cnt", 64'(bus.Stop_Cnt),   64'(m_scnt));
    chk("drop_cnt", 64'(bus.Drop_Cnt),   64'(m_dcnt));
  endtask

  // One clock: drive at negedge, advance model, check #1 after posedge.
  task automatic step(input logic rx, input logic [DATA_W-1:0] d, input logic pe,
                      input logic se, input logic rd, input logic clr);
    logic rd_ok, wr, drop;
    logic [DATA_W+1:0] e;
    @(negedge Clock_In);
    bus.Rx_Valid = rx; bus.Rx_dataOut = d; bus.Parity_Error = pe;
    bus.Stop_Error = se; bus.Rd_En = rd; bus.Clr_Stat = clr;
    rd_ok = rd && (q.size() > 0);
`ifdef RX_DROP_ERRORED_EN
    wr = rx && !pe && !se;
`else
    wr = rx;
`endif
    m_vld = rd_ok;
    if (rd_ok) begin
      e = q.pop_front();
`ifdef RX_DROP_ERRORED_EN
      m_perr = 1'b0; m_serr = 1'b0;
`else
      m_perr = e[DATA_W]; m_serr = e[DATA_W+1];
`endif
      m_data = e[DATA_W-1:0];
    end
    drop = 1'b0;
    if (wr) begin
      if (q.size() < DEPTH) q.push_back({se, pe, d});
      else drop = 1'b1;
    end
    if (clr) begin m_pcnt = 0; m_scnt = 0; m_dcnt = 0; m_ovf = 0; end
    if (rx && pe) m_pcnt = sat(m_pcnt + 1);
    if (rx && se) m_scnt = sat(m_scnt + 1);
    if (drop) begin m_dcnt = sat(m_dcnt + 1); m_ovf = 1'b1; end
    @(posedge Clock_In);
    #1 check_all();
  endtask

  task automatic wr_frame(input logic [DATA_W-1:0] d, input logic pe, input logic se);
    step(1'b1, d, pe, se, 1'b0, 1'b0);
  endtask

  task automatic rd_frame();
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) rd_frame();
  endtask

  initial begin
    Reset = 1'b0;
    bus.Rx_Valid = 0; bus.Rx_dataOut = '0; bus.Parity_Error = 0;
    bus.Stop_Error = 0; bus.Rd_En = 0; bus.Clr_Stat = 0;
    model_reset();
    repeat (2) @(posedge Clock_In);
    #1 check_all();
    @(negedge Clock_In) Reset = 1'b1;

    // basic in-order write then read
    for (int i = 0; i < 4; i++) wr_frame(32'd8900 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) rd_frame();

    // overfill: ninth frame dropped
    for (int i = 0; i < 9; i++) wr_frame(32'd8900 + 32'(i), 1'b0, 1'b0);
    drain();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

    // full with simultaneous read/write, then drain across the wrap
    for (int i = 0; i < 8; i++) wr_frame(32'd8900 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'd8909 + 32'(i), 1'b0, 1'b0, 1'b1, 1'b0);
    drain();

    // empty with simultaneous read/write: write only
    step(1'b1, 32'd8950, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();

    // error flags
    wr_frame(32'd8905, 1'b1, 1'b0);
    wr_frame(32'd8906, 1'b1, 1'b1);
    drain();

    // saturation then clear with a coincident parity error
    for (int i = 0; i < 20; i++) step(1'b1, 32'(i), 1'b1, 1'(i & 1), 1'(i & 1), 1'b0);
    step(1'b1, 32'd77, 1'b1, 1'b0, 1'b0, 1'b1);
    drain();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

    // async reset with data buffered, mid-cycle
    for (int i = 0; i < 5; i++) wr_frame(32'd8900 + 32'(i), 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2 Reset = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge Clock_In) Reset = 1'b1;
    rd_frame();

    // random traffic
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
